even_parity_serial_tx: RTL and testbench
========================================

Name: even_parity_serial_tx

Overview:
Serial transmitter that generates even parity. It is the sending end of the 4-bit even-parity link whose receiving end is the even_parity_checker.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Computes the even parity bit.
- Serialises the frame at a programmable bit period: start bit, data LSB-first, parity bit, stop bit.
- Also presents the latched word and parity in parallel, so the checker can be fed directly for loopback checks.

Parameters:
DATA_W, 4, data word width in bits; legal range >= 1.
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range >= 1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  reset; synchronous, active-low.
data_in  input  DATA_W  word to transmit; sampled only on the accept cycle.
in_valid  input  1  data_in holds a valid word.
in_ready  output  1  block can accept a word (high only in IDLE).
tx  output  1  serial line; idles high.
data_out  output  DATA_W  latched word of the current or last frame.
parity  output  1  even parity bit of data_out, equal to the XOR-reduce of data_out.
busy  output  1  high while a frame is in flight (any state except IDLE).
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset: when rst_n is low at a rising edge, the block is in IDLE after that edge, with the following outputs:
  - tx=1, in_ready=1, busy=0, frame_done=0
  - data_out=0, parity=0
  - bit counter=0, cycle counter=0
- Reset applies mid-frame too: the frame is aborted, tx=1 after the edge, nothing is retransmitted, and frame_done does not pulse.
- Accept: handshake when in_valid && in_ready at a rising edge. On that edge:
  - data_out <= data_in
  - parity <= ^data_in
  - state <= START
- Outside the accept cycle, in_valid and data_in are ignored; busy-time requests are neither queued nor dropped with error.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- Each state after IDLE holds for CLKS_PER_BIT cycles, or DATA_W*CLKS_PER_BIT cycles in the case of DATA.
- tx in each state:
  - IDLE: 1
  - START: 0
  - DATA: data_out[bit_idx], bit_idx counting 0 to DATA_W-1, LSB first
  - PARITY: parity
  - STOP: 1
- All outputs are registered.
- Latency: tx falls on the cycle immediately after the accept edge.
- Frame length is (DATA_W+3)*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle inclusive.
- frame_done is high exactly on the last STOP cycle. The next edge returns the block to IDLE, where in_ready=1.
- Minimum inter-frame gap is one IDLE cycle, so back-to-back words give a frame period of (DATA_W+3)*CLKS_PER_BIT+1 cycles.
- Cycle counter: width $clog2(CLKS_PER_BIT), minimum 1 bit. It wraps to 0 at CLKS_PER_BIT-1 and advances the state/bit index.
- CLKS_PER_BIT=1 must work: one cycle per bit, with no off-by-one.
- Bit index: width $clog2(DATA_W), minimum 1 bit. It must not wrap past DATA_W-1.
- Parity is even: the count of ones across data plus parity is always even. All-zero data gives parity 0.

Decomposition:
- Package epc_pkg contains:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - localparam function frame_cycles(DATA_W, CLKS_PER_BIT)
  - constants TX_IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1
- One natural sub-module, bit_timer: a CLKS_PER_BIT cycle counter with a sync clear and a one-cycle bit_tick output. The FSM, shift/select logic and parity live in the top module.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, in_valid=1 -> tx=1, in_ready=1, busy=0, frame_done=0, data_out=0, parity=0 throughout; no accept.
2. data_in=4'b1011 accepted (CLKS_PER_BIT=4) -> parity=1. Mid-bit samples of tx read 0,1,1,0,1,1,1 (start, d0..d3, parity, stop). Frame is 28 cycles, frame_done pulses on cycle 28, busy is high for 28 cycles.
3. data_in=4'b0000, 4'b1100 and 4'b1111 -> parity 0, 0, 0 respectively. Feeding data_out/parity to even_parity_checker gives error=0 for each.
4. Back-to-back: in_valid held high with 4'b0001 then 4'b0111 -> second start bit begins exactly 29 cycles after the first; parity=1 then 1.
5. Change in_valid/data_in mid-frame to 4'b1111 -> no effect on the tx bit stream or data_out; in_ready=0 until after frame_done.
6. Assert rst_n=0 for one edge during the DATA bit d2 of 4'b1011 -> tx=1 and busy=0 on the next cycle, no frame_done pulse; the next accept transmits a full, correct frame.

Source files
------------

// File: rtl/even_parity_serial_tx_pkg.sv
// epc_pkg: shared types and constants for the even-parity serial transmitter.
// Holds the FSM state enum, line levels and a frame-length helper.
package epc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;
  localparam logic STOP_LEVEL    = 1'b1;

  function automatic int frame_cycles(int data_w, int clks_per_bit);
    return (data_w + 3) * clks_per_bit;
  endfunction

endpackage

// File: rtl/even_parity_serial_tx_bit_timer.sv
// bit_timer: counts CLKS_PER_BIT cycles per serial bit.
// Ports: clk, rst_n, i_clr (sync clear), o_bit_tick (last cycle), o_pre_tick.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_bit_tick,
  output logic o_pre_tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LAST_I = CLKS_PER_BIT - 1;
  localparam int PRE_I =
    (CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];
  localparam logic [CW-1:0] PRE  = PRE_I[CW-1:0];

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_tick = (r_cnt == LAST);
  // Next cycle is the tick cycle; lets the top register frame_done.
  assign o_pre_tick = (CLKS_PER_BIT > 1) && (r_cnt == PRE);

endmodule

// File: rtl/even_parity_serial_tx.sv
// even_parity_serial_tx: valid/ready word in, start/data/parity/stop out on tx.
// Ports: data_in/in_valid/in_ready, tx, data_out/parity, busy, frame_done.
module even_parity_serial_tx
  import epc_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic [DATA_W-1:0] data_out,
  output logic              parity,
  output logic              busy,
  output logic              frame_done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LAST_IDX_I = DATA_W - 1;
  localparam logic [IW-1:0] LAST_IDX = LAST_IDX_I[IW-1:0];

  tx_state_t         r_state;
  logic [IW-1:0]     r_bit_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_parity;
  logic              r_tx;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_pre_tick;
  logic              w_clr;
  logic [IW-1:0]     w_idx_nxt;

  assign w_clr     = (r_state == IDLE);
  assign w_idx_nxt = r_bit_idx + 1'b1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .o_bit_tick(w_tick),
    .o_pre_tick(w_pre_tick)
  );

  // Outputs hold the value for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_tx      <= TX_IDLE_LEVEL;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid && r_ready) begin
            r_data    <= data_in;
            r_parity  <= ^data_in;
            r_bit_idx <= '0;
            r_state   <= START;
            r_tx      <= START_LEVEL;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_tx      <= r_data[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_IDX) begin
              r_state <= PARITY;
              r_tx    <= r_parity;
            end else begin
              r_bit_idx <= w_idx_nxt;
              r_tx      <= r_data[w_idx_nxt];
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_tx    <= STOP_LEVEL;
            // A one-cycle stop bit is its own last cycle.
            r_done  <= (CLKS_PER_BIT == 1);
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_tx    <= TX_IDLE_LEVEL;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_done <= w_pre_tick;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= TX_IDLE_LEVEL;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_ready;
  assign tx         = r_tx;
  assign data_out   = r_data;
  assign parity     = r_parity;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// tb_even_parity_serial_tx: directed self-checking bench for the tx block.
// Drives words on negedge, samples outputs on negedge.
module tb_even_parity_serial_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic [3:0] data_out;
  logic       parity;
  logic       busy;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  even_parity_serial_tx #(
    .DATA_W      (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .data_out  (data_out),
    .parity    (parity),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_rdy"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
  endtask

  // One full frame, expected parity given by hand.
  task automatic run_frame(input logic [3:0] d, input logic exp_p,
                           input logic poke, input string nm);
    logic [6:0] seq;
    logic [6:0] expq;
    int done_at, done_n, busy_n, rdy_n, dout_bad;
    seq = '0;
    done_at = -1; done_n = 0; busy_n = 0; rdy_n = 0; dout_bad = 0;
    expq = {1'b1, exp_p, d, 1'b0};
    @(negedge clk);
    data_in  = d;
    in_valid = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (poke && k == 5) begin
        in_valid = 1'b1;
        data_in  = 4'b1111;
      end
      if (poke && k == 28) in_valid = 1'b0;
      if ((k - 1) % 4 == 1) seq[(k-1)/4] = tx;
      busy_n += int'(busy);
      rdy_n  += int'(in_ready);
      if (frame_done) begin
        done_n++;
        done_at = k;
      end
      if (data_out !== d) dout_bad++;
    end
    check({nm, "_seq"}, seq, expq);
    check({nm, "_par"}, parity, exp_p);
    check({nm, "_chkerr"}, ^{data_out, parity}, 0);
    check({nm, "_done_at"}, done_at, 28);
    check({nm, "_done_n"}, done_n, 1);
    check({nm, "_busy_n"}, busy_n, 28);
    check({nm, "_rdy_n"}, rdy_n, 0);
    check({nm, "_dout"}, dout_bad, 0);
    @(negedge clk);
    chk_idle({nm, "_post"});
  endtask

  initial begin : main
    int s1, s2, done_n, tx_low, prev_busy, p1, p2;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in  = 4'b1011;
    repeat (3) begin
      @(negedge clk);
      chk_idle("rst");
      check("rst_dout", data_out, 0);
      check("rst_par", parity, 0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_idle("rel");
    check("rel_dout", data_out, 0);

    run_frame(4'b1011, 1'b1, 1'b0, "f1011");
    run_frame(4'b0000, 1'b0, 1'b0, "f0000");
    run_frame(4'b1100, 1'b0, 1'b0, "f1100");
    run_frame(4'b1111, 1'b0, 1'b0, "f1111");
    run_frame(4'b0110, 1'b0, 1'b1, "fpoke");

    // Back-to-back with in_valid held high.
    s1 = -1; s2 = -1; p1 = -1; p2 = -1;
    @(negedge clk);
    prev_busy = int'(busy);
    data_in  = 4'b0001;
    in_valid = 1'b1;
    for (int k = 1; k <= 80 && s2 < 0; k++) begin
      @(negedge clk);
      if (prev_busy == 0 && busy) begin
        if (s1 < 0) begin
          s1 = k;
          p1 = int'(parity);
          data_in = 4'b0111;
        end else begin
          s2 = k;
          p2 = int'(parity);
          in_valid = 1'b0;
        end
      end
      prev_busy = int'(busy);
    end
    in_valid = 1'b0;
    check("b2b_first", s1, 1);
    check("b2b_gap", s2 - s1, 29);
    check("b2b_p1", p1, 1);
    check("b2b_p2", p2, 1);
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    @(negedge clk);
    chk_idle("b2b_end");

    // Reset during d2 of 4'b1011.
    @(negedge clk);
    data_in  = 4'b1011;
    in_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("mrst");
    check("mrst_dout", data_out, 0);
    done_n = 0;
    tx_low = 0;
    repeat (40) begin
      @(negedge clk);
      done_n += int'(frame_done);
      tx_low += int'(!tx);
    end
    check("mrst_nodone", done_n, 0);
    check("mrst_txhigh", tx_low, 0);
    run_frame(4'b1011, 1'b1, 1'b0, "fafter");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
